// File: rtl/onewire_pkg.sv
// -----------------------------------------------------------------------------
// onewire_pkg
// Shared definitions for the onewire byte sequencer:
//   - command op encodings
//   - bit positions in the master control word (DAT, RST) and status word
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package onewire_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Master control word: DAT drives the bit (1 also opens a read slot),
    // RST requests a reset/presence slot.
    localparam int CTRL_DAT  = 0;
    localparam int CTRL_RST  = 1;

    // Master status word: sampled line level.
    localparam int STAT_LINE = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_IRQ,
        ST_STATUS,
        ST_NEXT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/onewire_sequencer.sv
// -----------------------------------------------------------------------------
// onewire_sequencer
// Byte-level command front end for the onewire master. Turns RESET / WRITE /
// READ byte commands into per-bit Avalon write (slot), interrupt wait and
// status read cycles, then returns one response per command.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_data
//   rsp_valid/ready     response handshake; rsp_data, rsp_presence, rsp_error
//   m_read, m_write     Avalon strobes to the master (registered)
//   m_address           always 0
//   m_writedata         control word (DAT/RST bits)
//   m_readdata          status word (line in bit STAT_LINE)
//   m_waitrequest       master stall
//   m_interrupt         slot-complete interrupt, cleared by status read
//   busy                high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module onewire_sequencer
    import onewire_pkg::*;
#(
    parameter int               AAW   = 1,
    parameter int               ADW   = 32,
    parameter int               TMO_W = 16,
    parameter logic [TMO_W-1:0] TMO   = 16'd50000
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [7:0]     cmd_data,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_data,
    output logic           rsp_presence,
    output logic           rsp_error,

    output logic           m_read,
    output logic           m_write,
    output logic [AAW-1:0] m_address,
    output logic [ADW-1:0] m_writedata,
    input  logic [ADW-1:0] m_readdata,
    input  logic           m_waitrequest,
    input  logic           m_interrupt,

    output logic           busy
);

    state_e           r_state, w_next;
    op_e              r_op;
    logic [7:0]       r_shreg;
    logic [2:0]       r_bitcnt;
    logic [TMO_W-1:0] r_wdog;
    logic             r_presence, r_error;
    logic             r_cmd_ready, r_write, r_read, r_rsp_valid;
    logic [ADW-1:0]   r_wdata;

    logic             w_accept, w_timeout, w_status_done;
    op_e              w_iss_op;
    logic             w_iss_bit, w_line;
    logic [ADW-1:0]   w_ctrl;
    logic             w_unused_rd;

    // Gate on the registered ready so nothing is taken in the cycle right
    // after reset release, while cmd_ready is still low.
    assign w_accept      = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
    assign w_timeout     = (r_state == ST_WAIT_IRQ) && !m_interrupt &&
                           (r_wdog == TMO - 1'b1);
    assign w_status_done = (r_state == ST_STATUS) && !m_waitrequest;
    assign w_line        = m_readdata[STAT_LINE];
    assign w_unused_rd   = ^m_readdata;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept)
                             w_next = (op_e'(cmd_op) == OP_RSVD) ? ST_RESP : ST_ISSUE;
            ST_ISSUE:    if (!m_waitrequest) w_next = ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (m_interrupt)    w_next = ST_STATUS;
                         else if (w_timeout) w_next = ST_RESP;
            ST_STATUS:   if (!m_waitrequest) w_next = ST_NEXT;
            ST_NEXT:     w_next = (r_op == OP_RESET || r_bitcnt == 3'd7) ? ST_RESP : ST_ISSUE;
            ST_RESP:     if (rsp_ready)      w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Control word for the slot about to be issued. On the accept edge the
    // op/data registers are not loaded yet, so take them from the command.
    always_comb begin
        w_iss_op  = w_accept ? op_e'(cmd_op) : r_op;
        w_iss_bit = w_accept ? cmd_data[0]   : r_shreg[0];
        w_ctrl    = '0;
        case (w_iss_op)
            OP_RESET: w_ctrl[CTRL_RST] = 1'b1;
            OP_WRITE: w_ctrl[CTRL_DAT] = w_iss_bit;
            default:  w_ctrl[CTRL_DAT] = 1'b1;   // READ: release the line
        endcase
    end

    // ---------------- datapath / registered outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= OP_RESET;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_wdog      <= '0;
            r_presence  <= 1'b0;
            r_error     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_wdata     <= '0;
        end else begin
            // Outputs follow the state being entered, so strobes rise with
            // the state and stay constant across waitrequest stalls.
            r_cmd_ready <= (w_next == ST_IDLE);
            r_write     <= (w_next == ST_ISSUE);
            r_read      <= (w_next == ST_STATUS);
            r_rsp_valid <= (w_next == ST_RESP);

            if (w_next == ST_ISSUE && r_state != ST_ISSUE)
                r_wdata <= w_ctrl;

            // Watchdog restarts on every WAIT_IRQ entry and saturates.
            if (r_state == ST_WAIT_IRQ) begin
                if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end

            if (w_accept) begin
                r_op       <= op_e'(cmd_op);
                r_shreg    <= (op_e'(cmd_op) == OP_WRITE) ? cmd_data : 8'h00;
                r_bitcnt   <= '0;
                r_presence <= 1'b0;
                r_error    <= (op_e'(cmd_op) == OP_RSVD);
            end

            if (w_timeout)
                r_error <= 1'b1;

            // LSB goes out first; the sampled line enters at the top, so
            // after eight slots the register holds the received byte.
            if (w_status_done) begin
                if (r_op == OP_RESET) r_presence <= ~w_line;
                else                  r_shreg    <= {w_line, r_shreg[7:1]};
            end

            if (r_state == ST_NEXT && w_next == ST_ISSUE)
                r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_shreg;
    assign rsp_presence = r_presence;
    assign rsp_error    = r_error;
    assign m_write      = r_write;
    assign m_read       = r_read;
    assign m_address    = '0;
    assign m_writedata  = r_wdata;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_onewire_sequencer.sv
// -----------------------------------------------------------------------------
// tb_onewire_sequencer
// Self-checking bench: a mock onewire master/slave answers the Avalon cycles,
// tasks drive commands and compare responses against a byte-level model.
// -----------------------------------------------------------------------------
module tb_onewire_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_data = 8'h00;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_presence, rsp_error;
    logic        m_read, m_write;
    logic [0:0]  m_address;
    logic [31:0] m_writedata, m_readdata;
    logic        m_waitrequest, m_interrupt;
    logic        busy;

    onewire_sequencer #(.AAW(1), .ADW(32), .TMO_W(16), .TMO(16'd16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_presence(rsp_presence), .rsp_error(rsp_error),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest), .m_interrupt(m_interrupt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    // Mock configuration, written by the tests.
    int          stall_lo = 0, stall_hi = 0, irq_max = 0;
    bit          irq_en = 1'b1;
    logic [7:0]  slave_byte = 8'hFF;   // bits the slave returns, LSB first
    bit          slave_present = 1'b1;

    // Mock observations, written only by the mock.
    logic [31:0] wr_log[$];
    int          rd_cnt = 0, stab_err = 0, wr_done_cyc = 0, rd_done_cyc = 0;

    // ---------------- mock master + slave ----------------
    initial begin : mock
        bit          in_x;
        int          st_cnt, cur_st, irq_cnt, slot;
        logic [34:0] snap;
        logic        ln;
        in_x = 0; st_cnt = 0; cur_st = 0; irq_cnt = 0; slot = 0; snap = '0; ln = 0;
        m_waitrequest = 0; m_interrupt = 0; m_readdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_x = 0; irq_cnt = 0; m_waitrequest = 0; m_interrupt = 0;
            end else begin
                if (cmd_valid && cmd_ready) slot = 0;
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) m_interrupt = 1;
                end
                if (m_write || m_read) begin
                    if (!in_x) begin
                        in_x   = 1; st_cnt = 0;
                        cur_st = $urandom_range(stall_hi, stall_lo);
                        snap   = {m_write, m_read, m_address, m_writedata};
                    end else if (snap !== {m_write, m_read, m_address, m_writedata}) begin
                        stab_err++;
                    end
                    if (st_cnt < cur_st) begin
                        m_waitrequest = 1; st_cnt++;
                    end else begin
                        m_waitrequest = 0; in_x = 0;
                        if (m_write) begin
                            wr_log.push_back(m_writedata);
                            wr_done_cyc = cyc + 1;
                            // Open-drain line: low if master drives 0 or slave pulls low.
                            if (m_writedata[1]) ln = !slave_present;
                            else begin
                                ln = m_writedata[0] & slave_byte[slot % 8];
                                slot++;
                            end
                            m_readdata = {31'b0, ln};
                            if (irq_en) begin
                                irq_cnt = $urandom_range(irq_max, 0);
                                if (irq_cnt == 0) m_interrupt = 1;
                            end
                        end else begin
                            rd_cnt++;
                            rd_done_cyc = cyc + 1;
                            m_interrupt = 0;
                        end
                    end
                end else begin
                    in_x = 0; m_waitrequest = 0;
                end
            end
        end
    end

    // ---------------- reference model (byte level) ----------------
    function automatic int exp_nwr(input logic [1:0] op);
        case (op)
            2'b00:        return 1;
            2'b01, 2'b10: return 8;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wr(input logic [1:0] op, input logic [7:0] d, input int i);
        case (op)
            2'b00:   return 32'h2;
            2'b01:   return {31'b0, d[i]};
            default: return 32'h1;
        endcase
    endfunction

    function automatic logic [7:0] exp_data(input logic [1:0] op, input logic [7:0] d,
                                            input logic [7:0] sl);
        case (op)
            2'b01:   return d & sl;   // read-back of an open-drain write
            2'b10:   return sl;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- command driver (observes, does not judge) ----------------
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input int hold,
                           input int budget, output bit ok, output logic acc,
                           output logic [7:0] r_d, output logic r_p, output logic r_e,
                           output int rsp_cyc, output bit stable, output logic rdy_after);
        int n;
        ok = 0; acc = 0; r_d = '0; r_p = 0; r_e = 0; rsp_cyc = 0; stable = 1; rdy_after = 0;
        @(posedge clk); #1;
        cmd_op = op; cmd_data = d; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < budget) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin cmd_valid = 0; return; end
        @(posedge clk); #1;                                   // accept edge just passed
        acc = ((op == 2'b11) ? rsp_valid : m_write) & busy;
        cmd_valid = 0; cmd_data = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < budget) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) return;
        rsp_cyc = cyc; r_d = rsp_data; r_p = rsp_presence; r_e = rsp_error;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid || cmd_ready || rsp_data !== r_d || rsp_presence !== r_p ||
                rsp_error !== r_e) stable = 0;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        rdy_after = cmd_ready & !busy;
        ok = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, m_write, m_read, rsp_valid, rsp_error, rsp_presence, busy} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0000000",
                {cmd_ready, m_write, m_read, rsp_valid, rsp_error, rsp_presence, busy});
        end
        n_cmp++;
        if ({m_writedata, m_address, rsp_data} !== 41'b0) begin
            n_bad++; $display("FAIL reset_data: got wd=%h ad=%h rd=%h want 0", m_writedata, m_address, rsp_data);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL release_ready_early: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_reset_cmd();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd; int rc, base, rb;
        stall_lo = 0; stall_hi = 0; irq_max = 3;
        for (int k = 0; k < 2; k++) begin
            slave_present = (k == 0);
            base = wr_log.size(); rb = rd_cnt;
            run_cmd(2'b00, 8'($urandom), 1, 500, ok, acc, rd, rp, re, rc, st, ra);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rst_cmd_done: got timeout want response"); end
            n_cmp++;
            if ({rd, rp, re} !== {8'h00, slave_present, 1'b0}) begin
                n_bad++; $display("FAIL rst_cmd_rsp: got d=%h p=%b e=%b want d=00 p=%b e=0", rd, rp, re, slave_present);
            end
            n_cmp++;
            if (wr_log.size() != base + 1 || rd_cnt != rb + 1) begin
                n_bad++; $display("FAIL rst_cmd_xfers: got wr=%0d rd=%0d want 1 1", wr_log.size() - base, rd_cnt - rb);
            end else begin
                n_cmp++;
                if (wr_log[base] !== 32'h2) begin n_bad++; $display("FAIL rst_cmd_word: got %h want 00000002", wr_log[base]); end
            end
        end
    endtask

    task automatic test_write_a5();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd, seq; int rc, base, hi;
        stall_lo = 0; stall_hi = 0; irq_max = 2; slave_byte = 8'hFF;
        base = wr_log.size();
        run_cmd(2'b01, 8'hA5, 0, 500, ok, acc, rd, rp, re, rc, st, ra);
        seq = '0; hi = 0;
        for (int i = 0; i < 8 && base + i < wr_log.size(); i++) begin
            seq[i] = wr_log[base + i][0];
            if (wr_log[base + i][31:1] != 0) hi++;
        end
        n_cmp++;
        if (!ok || !acc) begin n_bad++; $display("FAIL wr_a5_flow: got ok=%b acc=%b want 1 1", ok, acc); end
        n_cmp++;
        if (wr_log.size() - base != 8 || seq !== 8'hA5 || hi != 0) begin
            n_bad++; $display("FAIL wr_a5_bits: got n=%0d seq=%h hibits=%0d want 8 a5 0", wr_log.size() - base, seq, hi);
        end
        n_cmp++;
        if ({rd, rp, re} !== {8'hA5, 2'b00}) begin
            n_bad++; $display("FAIL wr_a5_rsp: got d=%h p=%b e=%b want a5 0 0", rd, rp, re);
        end
        n_cmp++;
        if (rc - rd_done_cyc != 1) begin n_bad++; $display("FAIL wr_a5_rsp_lat: got %0d want 1", rc - rd_done_cyc); end
    endtask

    task automatic test_read_96();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd; int rc, base, rb, badw;
        stall_lo = 0; stall_hi = 0; irq_max = 0; slave_byte = 8'h96;  // 0,1,1,0,1,0,0,1
        base = wr_log.size(); rb = rd_cnt;
        run_cmd(2'b10, 8'h5A, 0, 500, ok, acc, rd, rp, re, rc, st, ra);
        badw = 0;
        for (int i = base; i < wr_log.size(); i++) if (wr_log[i] !== 32'h1) badw++;
        n_cmp++;
        if (!ok || wr_log.size() - base != 8 || rd_cnt - rb != 8 || badw != 0) begin
            n_bad++; $display("FAIL rd_96_xfers: got ok=%b wr=%0d rd=%0d bad=%0d want 1 8 8 0",
                ok, wr_log.size() - base, rd_cnt - rb, badw);
        end
        n_cmp++;
        if ({rd, rp, re} !== {8'h96, 2'b00}) begin
            n_bad++; $display("FAIL rd_96_rsp: got d=%h p=%b e=%b want 96 0 0", rd, rp, re);
        end
    endtask

    task automatic test_stall();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd, d; logic [1:0] op; int rc, base, se;
        stall_lo = 3; stall_hi = 3; irq_max = 3;
        for (int k = 0; k < 2; k++) begin
            op = (k == 0) ? 2'b01 : 2'b10;
            d = 8'($urandom); slave_byte = 8'($urandom);
            base = wr_log.size(); se = stab_err;
            run_cmd(op, d, 2, 1000, ok, acc, rd, rp, re, rc, st, ra);
            n_cmp++;
            if (stab_err != se) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stab_err - se); end
            n_cmp++;
            if (!ok || {rd, rp, re} !== {exp_data(op, d, slave_byte), 2'b00} || wr_log.size() - base != 8) begin
                n_bad++; $display("FAIL stall_rsp op%0d: got ok=%b d=%h e=%b n=%0d want d=%h e=0 n=8",
                    op, ok, rd, re, wr_log.size() - base, exp_data(op, d, slave_byte));
            end
        end
        stall_lo = 0; stall_hi = 0;
    endtask

    task automatic test_timeout();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd, d; int rc;
        irq_en = 0; d = 8'($urandom);
        run_cmd(2'b01, d, 3, 500, ok, acc, rd, rp, re, rc, st, ra);
        irq_en = 1;
        n_cmp++;
        if (!ok || {rd, rp, re} !== {d, 2'b01}) begin
            n_bad++; $display("FAIL tmo_rsp: got ok=%b d=%h p=%b e=%b want d=%h p=0 e=1", ok, rd, rp, re, d);
        end
        n_cmp++;
        if (rc - wr_done_cyc != 16) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 16", rc - wr_done_cyc); end
        n_cmp++;
        if (!st || !ra) begin n_bad++; $display("FAIL tmo_handshake: got stable=%b ready=%b want 1 1", st, ra); end
    endtask

    task automatic test_reserved();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd; int rc, base, rb;
        base = wr_log.size(); rb = rd_cnt;
        run_cmd(2'b11, 8'hFF, 1, 100, ok, acc, rd, rp, re, rc, st, ra);
        n_cmp++;
        if (!ok || !acc) begin n_bad++; $display("FAIL rsvd_immediate: got ok=%b acc=%b want 1 1", ok, acc); end
        n_cmp++;
        if ({rd, rp, re} !== {8'h00, 2'b01} || wr_log.size() != base || rd_cnt != rb) begin
            n_bad++; $display("FAIL rsvd_rsp: got d=%h p=%b e=%b wr=%0d rd=%0d want 00 0 1 0 0",
                rd, rp, re, wr_log.size() - base, rd_cnt - rb);
        end
    endtask

    task automatic test_abort();
        bit ok, st, seen; logic acc, rp, re, ra; logic [7:0] rd; int rc, base, n;
        stall_lo = 0; stall_hi = 1; irq_max = 2; slave_byte = 8'($urandom); slave_present = 1;
        base = wr_log.size();
        @(posedge clk); #1;
        cmd_op = 2'b10; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_valid = 0;
        n = 0; seen = 0;
        while ((wr_log.size() < base + 5 || !m_read) && n < 500) begin
            @(posedge clk); #1; n++; seen |= rsp_valid;
        end
        n_cmp++;
        if (!m_read || wr_log.size() != base + 5) begin
            n_bad++; $display("FAIL abort_reach_bit4: got rd=%b wr=%0d want 1 5", m_read, wr_log.size() - base);
        end
        #2 rst = 0;
        #1;
        n_cmp++;
        if ({m_write, m_read, cmd_ready, rsp_valid, busy, rsp_error, rsp_presence} !== 7'b0 ||
            m_writedata !== 32'h0 || rsp_data !== 8'h00 || seen) begin
            n_bad++; $display("FAIL abort_outputs: got ctl=%b wd=%h d=%h seen=%b want 0",
                {m_write, m_read, cmd_ready, rsp_valid, busy, rsp_error, rsp_presence}, m_writedata, rsp_data, seen);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        base = wr_log.size();
        run_cmd(2'b00, 8'h00, 0, 500, ok, acc, rd, rp, re, rc, st, ra);
        n_cmp++;
        if (!ok || {rd, rp, re} !== {8'h00, 2'b10} || wr_log.size() != base + 1) begin
            n_bad++; $display("FAIL abort_recover: got ok=%b d=%h p=%b e=%b n=%0d want 1 00 1 0 1",
                ok, rd, rp, re, wr_log.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, st; logic acc, rp, re, ra; logic [7:0] rd, d; logic [1:0] op; int rc, base, rb, badw, nw;
        for (int k = 0; k < 24; k++) begin
            op = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            d = 8'($urandom); slave_byte = 8'($urandom); slave_present = 1'($urandom);
            stall_lo = 0; stall_hi = $urandom_range(3, 0); irq_max = $urandom_range(5, 0);
            base = wr_log.size(); rb = rd_cnt;
            run_cmd(op, d, $urandom_range(3, 0), 2000, ok, acc, rd, rp, re, rc, st, ra);
            nw = exp_nwr(op);
            badw = 0;
            for (int i = 0; i < nw && base + i < wr_log.size(); i++)
                if (wr_log[base + i] !== exp_wr(op, d, i)) badw++;
            n_cmp++;
            if (!ok || !acc || !st || !ra) begin
                n_bad++; $display("FAIL b2b_flow[%0d] op%0d: got ok=%b acc=%b stable=%b rdy=%b want 1111",
                    k, op, ok, acc, st, ra);
            end
            n_cmp++;
            if ({rd, rp, re} !== {exp_data(op, d, slave_byte), (op == 2'b00) && slave_present, op == 2'b11}) begin
                n_bad++; $display("FAIL b2b_rsp[%0d] op%0d: got d=%h p=%b e=%b want d=%h p=%b e=%b", k, op, rd, rp, re,
                    exp_data(op, d, slave_byte), (op == 2'b00) && slave_present, op == 2'b11);
            end
            n_cmp++;
            if (wr_log.size() - base != nw || rd_cnt - rb != nw || badw != 0) begin
                n_bad++; $display("FAIL b2b_xfers[%0d] op%0d: got wr=%0d rd=%0d bad=%0d want %0d %0d 0",
                    k, op, wr_log.size() - base, rd_cnt - rb, badw, nw, nw);
            end
            if (op != 2'b11) begin
                n_cmp++;
                if (rc - rd_done_cyc != 1) begin
                    n_bad++; $display("FAIL b2b_rsp_lat[%0d]: got %0d want 1", k, rc - rd_done_cyc);
                end
            end
        end
        stall_lo = 0; stall_hi = 0;
    endtask

    initial begin
        test_reset();
        test_reset_cmd();
        test_write_a5();
        test_read_96();
        test_stall();
        test_timeout();
        test_reserved();
        test_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish before 2 ms");
        $fatal(1, "simulation time limit");
    end

endmodule
